cv32e40p_mult_voter: RTL and testbench



---
 rtl/cv32e40p_mult_voter.sv | 186 ++++++++++++++++++
 tb/tb_cv32e40p_mult_voter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_mult_voter.sv
// rtl/cv32e40p_mult_voter.sv - majority voter and replica health tracker for the triplicated multiplier
// Optional: define MULT_VOTER_ERR_CNT_EN to implement the saturating err_cnt_o counter (tied to 0 otherwise).

module cv32e40p_mult_voter #(
    parameter int unsigned THRESHOLD = 3,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 ex_ready_i,
    input  logic                 clear_i,
    input  logic [31:0]          result_1_i,
    input  logic [31:0]          result_2_i,
    input  logic [31:0]          result_3_i,
    input  logic [2:0]           multicycle_i,
    input  logic [2:0]           mulh_active_i,
    input  logic [2:0]           ready_i,
    output logic [31:0]          result_o,
    output logic                 multicycle_o,
    output logic                 mulh_active_o,
    output logic                 ready_o,
    output logic                 fault_o,
    output logic                 uncorrectable_o,
    output logic [2:0]           replica_failed_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        HEALTHY = 2'd0,
        SUSPECT = 2'd1,
        FAILED  = 2'd2
    } rep_state_e;

    localparam logic [3:0] THR = 4'(THRESHOLD);

    rep_state_e  state_q [3];
    rep_state_e  state_d [3];
    logic [3:0]  cnt_q   [3];
    logic [3:0]  cnt_d   [3];
    logic        fault_q, fault_d;
    logic        uncorr_q, uncorr_d;

    logic [2:0]  failed;
    logic [2:0]  ctrl_1, ctrl_2, ctrl_3;
    logic [31:0] maj_res, sel_res;
    logic [2:0]  maj_ctrl, sel_ctrl;
    logic        cmp_res;
    logic [2:0]  mis;
    logic        any_mis, single_mis;
    logic        uncorr_evt, fault_evt;

    // Control fields packed as {ready, mulh_active, multicycle} per replica
    assign ctrl_1 = {ready_i[0], mulh_active_i[0], multicycle_i[0]};
    assign ctrl_2 = {ready_i[1], mulh_active_i[1], multicycle_i[1]};
    assign ctrl_3 = {ready_i[2], mulh_active_i[2], multicycle_i[2]};

    assign failed   = {state_q[2] == FAILED, state_q[1] == FAILED, state_q[0] == FAILED};
    assign maj_res  = (result_1_i & result_2_i) | (result_1_i & result_3_i) | (result_2_i & result_3_i);
    assign maj_ctrl = (ctrl_1 & ctrl_2) | (ctrl_1 & ctrl_3) | (ctrl_2 & ctrl_3);

    // Voted source: majority while all healthy, otherwise the lowest-index healthy replica
    always_comb begin
        sel_res  = maj_res;
        sel_ctrl = maj_ctrl;
        if (failed[0]) begin
            sel_res  = result_2_i;
            sel_ctrl = ctrl_2;
        end else if (failed[1] || failed[2]) begin
            sel_res  = result_1_i;
            sel_ctrl = ctrl_1;
        end
    end

    assign result_o      = sel_res;
    assign multicycle_o  = sel_ctrl[0];
    assign mulh_active_o = sel_ctrl[1];
    assign ready_o       = sel_ctrl[2];

    // The result only counts once EX actually takes it; control bits count on every compare
    assign cmp_res = ready_o & ex_ready_i;
    assign mis[0]  = ~failed[0] & ((ctrl_1 != sel_ctrl) | (cmp_res & (result_1_i != sel_res)));
    assign mis[1]  = ~failed[1] & ((ctrl_2 != sel_ctrl) | (cmp_res & (result_2_i != sel_res)));
    assign mis[2]  = ~failed[2] & ((ctrl_3 != sel_ctrl) | (cmp_res & (result_3_i != sel_res)));

    // Two or more mismatches means no pair agrees; with a replica already out, any mismatch
    // means the surviving pair disagrees. Both leave no trustworthy majority.
    assign any_mis    = |mis;
    assign single_mis = (mis == 3'b001) | (mis == 3'b010) | (mis == 3'b100);
    assign uncorr_evt = enable_i & any_mis & ((|failed) | ~single_mis);
    assign fault_evt  = enable_i & single_mis & ~(|failed);

    // Per-replica health FSMs and sticky status next-state
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
        end
        fault_d  = 1'b0;
        uncorr_d = uncorr_q;
        if (clear_i) begin
            for (int k = 0; k < 3; k++) begin
                state_d[k] = HEALTHY;
                cnt_d[k]   = 4'd0;
            end
            uncorr_d = 1'b0;
        end else if (uncorr_evt) begin
            uncorr_d = 1'b1;
        end else if (enable_i) begin
            fault_d = fault_evt;
            for (int k = 0; k < 3; k++) begin
                case (state_q[k])
                    HEALTHY: begin
                        if (mis[k]) begin
                            cnt_d[k]   = 4'd1;
                            state_d[k] = (THR == 4'd1) ? FAILED : SUSPECT;
                        end
                    end
                    SUSPECT: begin
                        if (mis[k]) begin
                            cnt_d[k] = cnt_q[k] + 4'd1;
                            if (cnt_q[k] + 4'd1 == THR) begin
                                state_d[k] = FAILED;
                            end
                        end else begin
                            cnt_d[k]   = 4'd0;
                            state_d[k] = HEALTHY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status and health registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= HEALTHY;
                cnt_q[k]   <= 4'd0;
            end
            fault_q  <= 1'b0;
            uncorr_q <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            fault_q  <= fault_d;
            uncorr_q <= uncorr_d;
        end
    end

    assign fault_o          = fault_q;
    assign uncorrectable_o  = uncorr_q;
    assign replica_failed_o = failed;

`ifdef MULT_VOTER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of compare events that saw any mismatch
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_i) begin
            err_cnt_d = '0;
        end else if (enable_i && any_mis && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_mult_voter.sv
// tb/tb_cv32e40p_mult_voter.sv - self-checking bench for cv32e40p_mult_voter

module tb_cv32e40p_mult_voter;

    localparam int unsigned THR   = 3;
    localparam int unsigned ERR_W = 4;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable_i, ex_ready_i, clear_i;
    logic [31:0]       result_1_i, result_2_i, result_3_i;
    logic [2:0]        multicycle_i, mulh_active_i, ready_i;
    logic [31:0]       result_o;
    logic              multicycle_o, mulh_active_o, ready_o;
    logic              fault_o, uncorrectable_o;
    logic [2:0]        replica_failed_o;
    logic [ERR_W-1:0]  err_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    cv32e40p_mult_voter #(.THRESHOLD(THR), .ERR_CNT_W(ERR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_i         (enable_i),
        .ex_ready_i       (ex_ready_i),
        .clear_i          (clear_i),
        .result_1_i       (result_1_i),
        .result_2_i       (result_2_i),
        .result_3_i       (result_3_i),
        .multicycle_i     (multicycle_i),
        .mulh_active_i    (mulh_active_i),
        .ready_i          (ready_i),
        .result_o         (result_o),
        .multicycle_o     (multicycle_o),
        .mulh_active_o    (mulh_active_o),
        .ready_o          (ready_o),
        .fault_o          (fault_o),
        .uncorrectable_o  (uncorrectable_o),
        .replica_failed_o (replica_failed_o),
        .err_cnt_o        (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [ERR_W-1:0] exp_err(input int n);
`ifdef MULT_VOTER_ERR_CNT_EN
        return ERR_W'(n);
`else
        return '0;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    int  m_consec [3];
    bit  m_failed [3];
    bit  m_fault, m_uncorr;
    int  m_err;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_consec[k] = 0;
            m_failed[k] = 0;
        end
        m_fault  = 0;
        m_uncorr = 0;
        m_err    = 0;
    endtask

    // Compare process: check outputs mid-cycle, then advance the model to the next edge
    always @(negedge clk) begin : cmp
        logic [31:0] r [3];
        logic [31:0] e_res;
        logic        e_mc, e_mh, e_rdy, acc;
        bit          mism [3];
        int          nf, nm, h, ones;
        r[0] = result_1_i; r[1] = result_2_i; r[2] = result_3_i;
        if (rst) model_reset();
        nf = 0; h = -1;
        for (int k = 0; k < 3; k++) begin
            if (m_failed[k]) nf++;
            else if (h < 0) h = k;
        end
        if (nf == 0) begin
            for (int b = 0; b < 32; b++) begin
                ones = 0;
                for (int k = 0; k < 3; k++) ones += int'(r[k][b]);
                e_res[b] = (ones >= 2);
            end
            e_mc  = ($countones(multicycle_i)  >= 2);
            e_mh  = ($countones(mulh_active_i) >= 2);
            e_rdy = ($countones(ready_i)       >= 2);
        end else begin
            e_res = r[h];
            e_mc  = multicycle_i[h];
            e_mh  = mulh_active_i[h];
            e_rdy = ready_i[h];
        end
        chk("result_o",      64'(result_o),      64'(e_res));
        chk("multicycle_o",  64'(multicycle_o),  64'(e_mc));
        chk("mulh_active_o", 64'(mulh_active_o), 64'(e_mh));
        chk("ready_o",       64'(ready_o),       64'(e_rdy));
        chk("fault_o",       64'(fault_o),       64'(m_fault));
        chk("uncorrectable_o", 64'(uncorrectable_o), 64'(m_uncorr));
        chk("replica_failed_o", 64'(replica_failed_o), 64'({m_failed[2], m_failed[1], m_failed[0]}));
        chk("err_cnt_o",     64'(err_cnt_o),     64'(exp_err(m_err)));

        if (rst || clear_i) begin
            model_reset();
        end else if (enable_i) begin
            acc = e_rdy && ex_ready_i;
            nm  = 0;
            for (int k = 0; k < 3; k++) begin
                mism[k] = 0;
                if (!m_failed[k])
                    mism[k] = (multicycle_i[k] != e_mc) || (mulh_active_i[k] != e_mh) ||
                              (ready_i[k] != e_rdy) || (acc && (r[k] != e_res));
                nm += int'(mism[k]);
            end
            if (nm > 0 && m_err < ERR_MAX) m_err++;
            if (nm >= 2 || (nf > 0 && nm > 0)) begin
                m_uncorr = 1;
                m_fault  = 0;
            end else begin
                m_fault = (nm == 1);
                for (int k = 0; k < 3; k++) begin
                    if (!m_failed[k]) begin
                        if (mism[k]) begin
                            m_consec[k]++;
                            if (m_consec[k] >= THR) m_failed[k] = 1;
                        end else begin
                            m_consec[k] = 0;
                        end
                    end
                end
            end
        end else begin
            m_fault = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [2:0] mc, input logic [2:0] mh, input logic [2:0] rdy,
                         input logic en, input logic exr, input logic clr);
        result_1_i = a; result_2_i = b; result_3_i = c;
        multicycle_i = mc; mulh_active_i = mh; ready_i = rdy;
        enable_i = en; ex_ready_i = exr; clear_i = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        drive(a, b, c, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0);
        tick();
    endtask

    localparam logic [31:0] V = 32'h1234_5678;

    initial begin
        rst = 1'b1;
        drive(V, V, V, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("reset_failed", 64'(replica_failed_o), 64'd0);
        chk("reset_uncorr", 64'(uncorrectable_o), 64'd0);
        chk("reset_fault",  64'(fault_o), 64'd0);
        rst = 1'b0;

        // all agree
        drive(V, V, V, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0);
        #1 chk("agree_result", 64'(result_o), 64'(V));
        tick();
        chk("agree_fault", 64'(fault_o), 64'd0);
        chk("agree_err", 64'(err_cnt_o), 64'(exp_err(0)));

        // replica 2 single-bit mismatch: corrected, fault pulses once
        drive(V, V + 1, V, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0);
        #1 chk("r2_voted", 64'(result_o), 64'(V));
        tick();
        chk("r2_fault", 64'(fault_o), 64'd1);
        chk("r2_err", 64'(err_cnt_o), 64'(exp_err(1)));
        drive(V, V + 1, V, 3'b000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0);
        tick();
        chk("idle_fault", 64'(fault_o), 64'd0);
        acc3(V, V, V);

        // result differs but EX not accepting: not compared
        drive(V, V, 32'hDEAD_BEEF, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0);
        tick();
        chk("noacc_fault", 64'(fault_o), 64'd0);

        // replica 3 fails after three consecutive mismatches
        acc3(V, V, 32'h0);
        acc3(V, V, 32'h1);
        chk("r3_not_yet", 64'(replica_failed_o), 64'd0);
        acc3(V, V, 32'h2);
        chk("r3_failed", 64'(replica_failed_o), 64'b100);
        chk("r3_err", 64'(err_cnt_o), 64'(exp_err(4)));

        // replica 3 out: replica 1 is the source, replicas 1/2 disagree -> uncorrectable
        drive(32'hA, 32'hB, 32'hB, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0);
        #1 chk("fail_src", 64'(result_o), 64'hA);
        tick();
        chk("uncorr_set", 64'(uncorrectable_o), 64'd1);
        chk("uncorr_failed", 64'(replica_failed_o), 64'b100);
        chk("uncorr_fault", 64'(fault_o), 64'd0);
        acc3(V, V, 32'h0);
        chk("uncorr_sticky", 64'(uncorrectable_o), 64'd1);

        // clear wins over a same-cycle replica 1 mismatch
        drive(32'h0, V, V, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b1);
        tick();
        chk("clr_failed", 64'(replica_failed_o), 64'd0);
        chk("clr_uncorr", 64'(uncorrectable_o), 64'd0);
        chk("clr_err", 64'(err_cnt_o), 64'(exp_err(0)));

        // replica 1: two mismatches, agree, two more (control-bit mismatches) -> never fails
        acc3(32'h1, V, V);
        acc3(32'h2, V, V);
        acc3(V, V, V);
        drive(V, V, V, 3'b000, 3'b001, 3'b111, 1'b1, 1'b0, 1'b0);
        tick();
        drive(V, V, V, 3'b001, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0);
        tick();
        chk("r1_never_failed", 64'(replica_failed_o), 64'd0);
        chk("r1_err", 64'(err_cnt_o), 64'(exp_err(4)));

        // three-way disagreement with everyone healthy
        drive(32'h1, 32'h2, 32'h4, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0);
        #1 chk("3way_vote", 64'(result_o), 64'h0);
        tick();
        chk("3way_uncorr", 64'(uncorrectable_o), 64'd1);
        chk("3way_failed", 64'(replica_failed_o), 64'd0);

        // saturate the error counter
        for (int i = 0; i < 14; i++) acc3(32'h1, 32'h2, 32'h4);
        chk("err_sat", 64'(err_cnt_o), 64'(exp_err(ERR_MAX)));

        // asynchronous reset mid-sequence
        drive(V, V, V, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b1);
        tick();
        acc3(V, 32'h5, V);
        acc3(V, 32'h6, V);
        acc3(V, 32'h7, V);
        chk("r2_failed", 64'(replica_failed_o), 64'b010);
        #2 rst = 1'b1;
        #1 chk("arst_failed", 64'(replica_failed_o), 64'd0);
        chk("arst_err", 64'(err_cnt_o), 64'd0);
        tick();
        rst = 1'b0;
        acc3(V, V, V);
        acc3(32'h9, 32'hC, V);
        drive(V, V, V, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
